// File: rtl/link_controller.sv
// Half-duplex optical link controller: arbitrates the channel between the
// decoder (RX) and the encoder (TX) and buffers decoded packets in a small FIFO.
`ifndef PACKET_SIZE
`define PACKET_SIZE 8
`endif

module link_controller #(
  parameter int PACKET_SIZE = `PACKET_SIZE,
  parameter int TIMEOUT     = 64,
  parameter int GUARD       = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   signal,
  input  logic                   dec_irq,
  input  logic [PACKET_SIZE-1:0] dec_data,
  output logic                   dec_reset,
  input  logic                   tx_req,
  input  logic                   tx_done,
  output logic                   tx_grant,
  input  logic                   rd_en,
  output logic [PACKET_SIZE-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   overflow,
  output logic                   timeout_err
);
  localparam int ADDR_W  = $clog2(FIFO_DEPTH);
  localparam int PTR_W   = ADDR_W + 1;
  localparam int GUARD_W = $clog2(GUARD + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RX, ST_TX, ST_GUARD} state_t;

  state_t               state_q, state_d;
  logic [15:0]          timer_q, timer_d;
  logic [GUARD_W-1:0]   guard_cnt_q, guard_cnt_d;
  logic                 irq_prev_q, irq_prev_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PACKET_SIZE-1:0] mem [FIFO_DEPTH];

  logic irq_edge, rx_timeout, push;
  logic fifo_empty, fifo_full, do_push, do_pop;

  // The irq edge takes priority over a simultaneous timeout.
  assign irq_edge   = (state_q == ST_RX) && dec_irq && !irq_prev_q;
  assign rx_timeout = (state_q == ST_RX) && !irq_edge && (timer_q == 16'(TIMEOUT - 1));
  assign irq_prev_d = dec_irq;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      guard_cnt_q <= '0;
      irq_prev_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      guard_cnt_q <= guard_cnt_d;
      irq_prev_q  <= irq_prev_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q[ADDR_W-1:0]] <= dec_data;
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    guard_cnt_d = guard_cnt_q;
    case (state_q)
      ST_IDLE: begin
        timer_d     = '0;
        guard_cnt_d = '0;
        if (signal)      state_d = ST_RX;
        else if (tx_req) state_d = ST_TX;
      end
      ST_RX: begin
        timer_d = signal ? 16'd0 : timer_q + 16'd1;
        if (irq_edge || rx_timeout) state_d = ST_IDLE;
      end
      ST_TX: begin
        guard_cnt_d = '0;
        if (tx_done) state_d = ST_GUARD;
      end
      ST_GUARD: begin
        if (guard_cnt_q == GUARD_W'(GUARD - 1)) state_d = ST_IDLE;
        else guard_cnt_d = guard_cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decoder is held in reset while our own transmission could echo back.
  always_comb begin
    dec_reset   = (state_q == ST_TX) || (state_q == ST_GUARD) || rx_timeout;
    tx_grant    = (state_q == ST_TX);
    timeout_err = rx_timeout;
    push        = irq_edge;
  end

  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    do_pop     = rd_en && !fifo_empty;
    do_push    = push && (!fifo_full || do_pop);
    overflow   = push && fifo_full && !do_pop;
    wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rx_valid   = !fifo_empty;
    rx_data    = fifo_empty ? '0 : mem[rd_ptr_q[ADDR_W-1:0]];
  end

endmodule
